// File: rtl/core_management_hub.sv
// Round-robin management hub: MASTER_COUNT masters onto CORE_COUNT core ports plus local regs.
// Latency: ack 2 cycles after grant for local/error accesses, 2 + core wait cycles for core accesses.
// Backpressure: masters hold requests until master_ack; a core stalls via core_ack, bounded by the timeout watchdog.
// Optional: CORE_MANAGEMENT_HUB_AUTO_HALT_EN lets a nonzero core error code clear that core's run bit.
module core_management_hub #(
  parameter int MASTER_COUNT   = 2,
  parameter int CORE_COUNT     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MASTER_COUNT-1:0]   master_writeEnable,
  input  logic [MASTER_COUNT-1:0]   master_readEnable,
  input  logic [4*MASTER_COUNT-1:0] master_byteSelect,
  input  logic [20*MASTER_COUNT-1:0] master_address,
  input  logic [32*MASTER_COUNT-1:0] master_writeData,
  output logic [31:0]               master_readData,
  output logic [MASTER_COUNT-1:0]   master_ack,
  output logic [MASTER_COUNT-1:0]   master_error,
  output logic [CORE_COUNT-1:0]     core_run,
  output logic [CORE_COUNT-1:0]     core_writeEnable,
  output logic [CORE_COUNT-1:0]     core_readEnable,
  output logic [3:0]                core_byteSelect,
  output logic [15:0]               core_address,
  output logic [31:0]               core_writeData,
  input  logic [32*CORE_COUNT-1:0]  core_readData,
  input  logic [CORE_COUNT-1:0]     core_ack,
  input  logic [4*CORE_COUNT-1:0]   core_errorCode
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched transaction
  logic [2:0]            r_grant;
  logic                  r_we;
  logic [3:0]            r_bsel;
  logic [19:0]           r_addr;
  logic [31:0]           r_wdata;
  // Bookkeeping
  logic [2:0]            r_last;
  logic [7:0]            r_cnt;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  r_tflag;
  logic [2:0]            r_tidx;
  logic [CORE_COUNT-1:0] r_run;

  logic                  w_any;
  logic                  w_found;
  logic [2:0]            w_cand;
  logic [2:0]            w_gnt;
  logic                  w_sel_we;
  logic [3:0]            w_sel_bsel;
  logic [19:0]           w_sel_addr;
  logic [31:0]           w_sel_wdata;

  logic                  w_is_local;
  logic                  w_is_core;
  logic                  w_core_ok;
  logic                  w_tgt_run;
  logic                  w_tgt_ack;
  logic [31:0]           w_tgt_rdata;
  logic [CORE_COUNT-1:0] w_tgt_vec;
  logic                  w_timeout;
  logic [11:0]           w_off;
  logic [31:0]           w_local_rdata;
  logic                  w_run_wr;
  logic                  w_tflag_clr;

  // Round-robin: first requester strictly after the last granted master
  always_comb begin
    w_any   = |(master_writeEnable | master_readEnable);
    w_found = 1'b0;
    w_cand  = '0;
    w_gnt   = '0;
    for (int i = 1; i <= MASTER_COUNT; i++) begin
      w_cand = 3'((int'(r_last) + i) % MASTER_COUNT);
      for (int m = 0; m < MASTER_COUNT; m++) begin
        if (!w_found && (w_cand == 3'(m)) && (master_writeEnable[m] || master_readEnable[m])) begin
          w_gnt   = w_cand;
          w_found = 1'b1;
        end
      end
    end
  end

  // Mux the granted master's request fields for latching
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_bsel  = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int m = 0; m < MASTER_COUNT; m++) begin
      if (w_gnt == 3'(m)) begin
        w_sel_we    = master_writeEnable[m];
        w_sel_bsel  = master_byteSelect[4*m +: 4];
        w_sel_addr  = master_address[20*m +: 20];
        w_sel_wdata = master_writeData[32*m +: 32];
      end
    end
  end

  // Decode the latched address into local / core target
  always_comb begin
    w_off       = r_addr[11:0];
    w_is_local  = (r_addr[19:12] == 8'h00);
    w_is_core   = 1'b0;
    w_tgt_run   = 1'b0;
    w_tgt_ack   = 1'b0;
    w_tgt_rdata = '0;
    w_tgt_vec   = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (r_addr[19:16] == 4'(k + 1)) begin
        w_is_core    = 1'b1;
        w_tgt_run    = r_run[k];
        w_tgt_ack    = core_ack[k];
        w_tgt_rdata  = core_readData[32*k +: 32];
        w_tgt_vec[k] = 1'b1;
      end
    end
    // A running core is owned by its own pipeline; management access is refused
    w_core_ok = w_is_core && !w_tgt_run;
    w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));
  end

  // Local register read mux
  always_comb begin
    w_local_rdata = '0;
    if (w_off == 12'h000) begin
      w_local_rdata[CORE_COUNT-1:0] = r_run;
    end else if (w_off == 12'h004) begin
      w_local_rdata = {21'b0, r_tidx, 7'b0, r_tflag};
    end
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (w_off == 12'(256 + 4*k)) begin
        w_local_rdata = {27'b0, r_run[k], core_errorCode[4*k +: 4]};
      end
    end
  end

  // Local register writes commit at the end of RESPOND
  always_comb begin
    w_run_wr    = (r_state == S_RESPOND) && r_we && w_is_local && (w_off == 12'h000) && r_bsel[0];
    w_tflag_clr = (r_state == S_RESPOND) && r_we && w_is_local && (w_off == 12'h004) && r_bsel[0] && r_wdata[0];
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (w_is_local || !w_core_ok || w_tgt_ack || w_timeout) begin
          w_state_nxt = S_RESPOND;
        end
      end
      S_RESPOND: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Transaction latch, response capture, watchdog and status flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant <= '0;
      r_we    <= 1'b0;
      r_bsel  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_last  <= 3'(MASTER_COUNT - 1);
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_tflag <= 1'b0;
      r_tidx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_gnt;
            r_we    <= w_sel_we;
            r_bsel  <= w_sel_bsel;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= '0;
          end
        end
        S_ACCESS: begin
          if (w_is_local) begin
            r_err   <= 1'b0;
            r_rdata <= r_we ? 32'h0 : w_local_rdata;
          end else if (w_core_ok) begin
            if (w_tgt_ack) begin
              r_err   <= 1'b0;
              r_rdata <= r_we ? 32'h0 : w_tgt_rdata;
            end else if (w_timeout) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_tflag <= 1'b1;
              r_tidx  <= r_grant;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        S_RESPOND: begin
          r_last <= r_grant;
          if (w_tflag_clr) r_tflag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CORE_MANAGEMENT_HUB_AUTO_HALT_EN
  logic [4*CORE_COUNT-1:0] r_errq;
  logic [CORE_COUNT-1:0]   w_halt;

  // Registered error codes; a nonzero code forces the core's run bit low
  always_comb begin
    w_halt = '0;
    for (int k = 0; k < CORE_COUNT; k++) w_halt[k] = |r_errq[4*k +: 4];
  end

  // Run bits: control-register write, overridden by error halt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_errq <= '0;
      r_run  <= '0;
    end else begin
      r_errq <= core_errorCode;
      r_run  <= (w_run_wr ? r_wdata[CORE_COUNT-1:0] : r_run) & ~w_halt;
    end
  end
`else
  // Run bits change only through control-register writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_run <= '0;
    else if (w_run_wr) r_run <= r_wdata[CORE_COUNT-1:0];
  end
`endif

  // Outputs decoded from state and latched transaction
  always_comb begin
    master_ack       = '0;
    master_error     = '0;
    master_readData  = '0;
    core_writeEnable = '0;
    core_readEnable  = '0;
    core_byteSelect  = '0;
    core_address     = '0;
    core_writeData   = '0;
    if (r_state == S_RESPOND) begin
      for (int m = 0; m < MASTER_COUNT; m++) begin
        if (r_grant == 3'(m)) begin
          master_ack[m]   = 1'b1;
          master_error[m] = r_err;
        end
      end
      master_readData = r_rdata;
    end
    if ((r_state == S_ACCESS) && w_core_ok) begin
      core_writeEnable = r_we ? w_tgt_vec : '0;
      core_readEnable  = r_we ? '0 : w_tgt_vec;
      core_byteSelect  = r_bsel;
      core_address     = r_addr[15:0];
      core_writeData   = r_wdata;
    end
  end

  assign core_run = r_run;

endmodule

// File: tb/tb_core_management_hub.sv
// Bench for core_management_hub: directed table, random traffic against a transaction-level model,
// plus hand sequences for arbitration, mid-transaction reset and auto-halt.
module tb_core_management_hub;
  localparam int MC = 2;
  localparam int CC = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [MC-1:0]    mw_we, mw_re;
  logic [4*MC-1:0]  mw_bsel;
  logic [20*MC-1:0] mw_addr;
  logic [32*MC-1:0] mw_wdata;
  logic [31:0]      master_readData;
  logic [MC-1:0]    master_ack, master_error;
  logic [CC-1:0]    core_run, core_writeEnable, core_readEnable;
  logic [3:0]       core_byteSelect;
  logic [15:0]      core_address;
  logic [31:0]      core_writeData;
  logic [32*CC-1:0] core_readData;
  logic [CC-1:0]    core_ack;
  logic [4*CC-1:0]  core_errorCode;

  int          c_dly [CC];
  logic [31:0] c_rd  [CC];
  assign core_readData = {c_rd[1], c_rd[0]};

  core_management_hub #(.MASTER_COUNT(MC), .CORE_COUNT(CC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .master_writeEnable(mw_we), .master_readEnable(mw_re), .master_byteSelect(mw_bsel),
    .master_address(mw_addr), .master_writeData(mw_wdata), .master_readData(master_readData),
    .master_ack(master_ack), .master_error(master_error),
    .core_run(core_run), .core_writeEnable(core_writeEnable), .core_readEnable(core_readEnable),
    .core_byteSelect(core_byteSelect), .core_address(core_address), .core_writeData(core_writeData),
    .core_readData(core_readData), .core_ack(core_ack), .core_errorCode(core_errorCode)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Core responder: ack after c_dly cycles of a held strobe
  int wcnt [CC];
  initial begin
    core_ack = '0;
    for (int k = 0; k < CC; k++) wcnt[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < CC; k++) begin
        core_ack[k] = 1'b0;
        if (core_writeEnable[k] || core_readEnable[k]) begin
          if (wcnt[k] == c_dly[k]) core_ack[k] = 1'b1;
          wcnt[k]++;
        end else begin
          wcnt[k] = 0;
        end
      end
    end
  end

  // Protocol monitors
  int multi_ack = 0, bad_strobe = 0, stray_rdata = 0;
  always @(negedge clk) begin
    if (rst) begin
      if ($countones(master_ack) > 1) multi_ack++;
      for (int k = 0; k < CC; k++)
        if ((core_writeEnable[k] || core_readEnable[k]) && core_run[k]) bad_strobe++;
      if (master_ack == '0 && master_readData != 32'h0) stray_rdata++;
    end
  end

  // Transaction-level reference model
  int m_run, m_tflag, m_tidx, m_last;

  task automatic model_reset();
    m_run = 0; m_tflag = 0; m_tidx = 0; m_last = MC - 1;
  endtask

  task automatic model_access(input int m, input bit we, input logic [19:0] a, input logic [31:0] wd,
                              input logic [3:0] bs, input int dly, input logic [31:0] crd,
                              output logic [31:0] erd, output bit eerr, output int elat);
    int hi, off, k;
    hi = int'(a[19:16]); off = int'(a[11:0]);
    erd = 0; eerr = 0; elat = 2;
    if (a[19:12] == 8'h00) begin
      if (we) begin
        if (off == 0 && bs[0]) m_run = int'(wd) & ((1 << CC) - 1);
        if (off == 4 && bs[0] && wd[0]) m_tflag = 0;
      end else if (off == 0) erd = 32'(m_run);
      else if (off == 4) erd = 32'(m_tflag + (m_tidx << 8));
      else if (off >= 256 && off < 256 + 4*CC && off % 4 == 0) begin
        k = (off - 256) / 4;
        erd = 32'((((m_run >> k) & 1) << 4) + int'(core_errorCode[4*k +: 4]));
      end
    end else if (hi >= 1 && hi <= CC) begin
      k = hi - 1;
      if ((m_run >> k) & 1) eerr = 1;
      else if (dly >= TO) begin
        eerr = 1; elat = TO + 1; m_tflag = 1; m_tidx = m;
      end else begin
        elat = dly + 2;
        erd = we ? 32'h0 : crd;
      end
    end else eerr = 1;
    m_last = m;
  endtask

  task automatic do_access(input int m, input bit we, input logic [19:0] a, input logic [31:0] wd,
                           input logic [3:0] bs, input int dly, input logic [31:0] crd,
                           output logic [31:0] rd, output logic er, output int lat);
    bit got;
    for (int k = 0; k < CC; k++) begin c_dly[k] = dly; c_rd[k] = crd; end
    @(negedge clk);
    mw_addr[20*m +: 20] = a; mw_wdata[32*m +: 32] = wd; mw_bsel[4*m +: 4] = bs;
    mw_we[m] = we; mw_re[m] = !we;
    got = 0; lat = 0; rd = 0; er = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (master_ack[m]) begin got = 1; rd = master_readData; er = master_error[m]; end
    end
    mw_we[m] = 1'b0; mw_re[m] = 1'b0;
    if (!got) lat = -1;
  endtask

  task automatic xact(input string tag, input int m, input bit we, input logic [19:0] a,
                      input logic [31:0] wd, input logic [3:0] bs, input int dly, input logic [31:0] crd,
                      input logic [31:0] erd, input bit eerr, input int elat);
    logic [31:0] rd; logic er; int lat;
    do_access(m, we, a, wd, bs, dly, crd, rd, er, lat);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_error"}, 32'(er), 32'(eerr));
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    @(negedge clk);
    check({tag, "_core_run"}, 32'(core_run), 32'(m_run));
  endtask

  typedef struct {
    int m; bit we; logic [19:0] a; logic [31:0] wd; logic [3:0] bs; int dly; logic [31:0] crd;
    logic [31:0] erd; bit eerr; int elat;
  } vec_t;
  vec_t tbl[$];

  initial begin
    logic [31:0] erd; bit eerr; int elat; int acks, expm;
    rst = 1'b0; mw_we = '0; mw_re = '0; mw_bsel = '0; mw_addr = '0; mw_wdata = '0;
    core_errorCode = '0;
    for (int k = 0; k < CC; k++) begin c_dly[k] = 0; c_rd[k] = 0; end
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(master_ack), 0);
    check("reset_rdata", master_readData, 0);
    check("reset_run", 32'(core_run), 0);
    check("reset_strobes", 32'({core_writeEnable, core_readEnable}), 0);
    rst = 1'b1;
    model_reset();

    //              m we addr        wdata         bs   dly crd            exp_rd        err lat
    tbl.push_back('{0, 1, 20'h00000, 32'h00000003, 4'hF, 0, 32'h0,        32'h0,        0, 2});
    tbl.push_back('{0, 0, 20'h00004, 32'h0,        4'hF, 0, 32'h0,        32'h0,        0, 2});
    tbl.push_back('{0, 0, 20'h00000, 32'h0,        4'hF, 0, 32'h0,        32'h3,        0, 2});
    tbl.push_back('{1, 0, 20'h20000, 32'h0,        4'hF, 0, 32'h11111111, 32'h0,        1, 2});
    tbl.push_back('{1, 1, 20'h20000, 32'h55,       4'hF, 0, 32'h0,        32'h0,        1, 2});
    tbl.push_back('{0, 1, 20'h00000, 32'h0,        4'h1, 0, 32'h0,        32'h0,        0, 2});
    tbl.push_back('{1, 0, 20'h10010, 32'h0,        4'hF, 3, 32'hDEADBEEF, 32'hDEADBEEF, 0, 5});
    tbl.push_back('{0, 1, 20'h10004, 32'hCAFE,     4'h3, 0, 32'h0,        32'h0,        0, 2});
    tbl.push_back('{1, 0, 20'h20000, 32'h0,        4'hF, 15, 32'h0,       32'h0,        1, 5});
    tbl.push_back('{0, 0, 20'h00004, 32'h0,        4'hF, 0, 32'h0,        32'h101,      0, 2});
    tbl.push_back('{0, 1, 20'h00004, 32'h1,        4'h1, 0, 32'h0,        32'h0,        0, 2});
    tbl.push_back('{0, 0, 20'h00004, 32'h0,        4'hF, 0, 32'h0,        32'h100,      0, 2});
    tbl.push_back('{0, 1, 20'h00000, 32'h3,        4'hE, 0, 32'h0,        32'h0,        0, 2});
    tbl.push_back('{0, 0, 20'h00000, 32'h0,        4'hF, 0, 32'h0,        32'h0,        0, 2});
    tbl.push_back('{1, 1, 20'h00000, 32'h2,        4'h1, 0, 32'h0,        32'h0,        0, 2});
    tbl.push_back('{1, 0, 20'h00104, 32'h0,        4'hF, 0, 32'h0,        32'h10,       0, 2});
    tbl.push_back('{1, 0, 20'h00100, 32'h0,        4'hF, 0, 32'h0,        32'h0,        0, 2});
    tbl.push_back('{0, 0, 20'h30000, 32'h0,        4'hF, 0, 32'h0,        32'h0,        1, 2});
    tbl.push_back('{0, 0, 20'h05000, 32'h0,        4'hF, 0, 32'h0,        32'h0,        1, 2});
    tbl.push_back('{0, 0, 20'h00200, 32'h0,        4'hF, 0, 32'h0,        32'h0,        0, 2});
    tbl.push_back('{0, 1, 20'h00000, 32'h0,        4'h1, 0, 32'h0,        32'h0,        0, 2});
    tbl.push_back('{1, 0, 20'h10000, 32'h0,        4'hF, 0, 32'h12345678, 32'h12345678, 0, 2});

    foreach (tbl[i]) begin
      model_access(tbl[i].m, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].bs, tbl[i].dly, tbl[i].crd, erd, eerr, elat);
      xact($sformatf("vec%0d", i), tbl[i].m, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].bs,
           tbl[i].dly, tbl[i].crd, tbl[i].erd, tbl[i].eerr, tbl[i].elat);
    end

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      int m, kind, dly; bit we; logic [19:0] a; logic [31:0] wd, crd; logic [3:0] bs;
      m = $urandom_range(0, MC - 1); kind = $urandom_range(0, 6);
      wd = $urandom; crd = $urandom; bs = 4'($urandom_range(0, 15)); dly = 0; we = 0;
      case (kind)
        0: begin a = 20'h00000; we = 1; end
        1: a = ($urandom_range(0, 1) == 1) ? 20'h00004 : 20'h00000;
        2: begin a = 20'h00004; we = 1; wd = 32'($urandom_range(0, 1)); end
        3: a = 20'(256 + 4 * $urandom_range(0, 2));
        6: a = ($urandom_range(0, 1) == 1) ? 20'(32'h00800 + 4 * $urandom_range(0, 15)) : 20'h3F000;
        default: begin
          a = 20'((32'($urandom_range(1, 2)) << 16) | (32'($urandom_range(0, 255)) << 2));
          we = 1'($urandom_range(0, 1)); dly = $urandom_range(0, 5);
        end
      endcase
      model_access(m, we, a, wd, bs, dly, crd, erd, eerr, elat);
      xact($sformatf("rnd%0d", n), m, we, a, wd, bs, dly, crd, erd, eerr, elat);
    end

    // Reset in the middle of a stalled core access
    model_access(0, 1, 20'h00000, 32'h0, 4'h1, 0, 32'h0, erd, eerr, elat);
    xact("halt_all", 0, 1, 20'h00000, 32'h0, 4'h1, 0, 32'h0, erd, eerr, elat);
    c_dly[0] = 15;
    @(negedge clk);
    mw_addr[19:0] = 20'h10000; mw_re[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_strobe", 32'(core_readEnable[0]), 1);
    rst = 1'b0;
    #1;
    check("midrst_ack", 32'(master_ack), 0);
    check("midrst_strobe_off", 32'(core_readEnable), 0);
    mw_re[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    acks = 0;
    repeat (5) begin @(negedge clk); if (master_ack != '0) acks++; end
    check("midrst_no_ack", 32'(acks), 0);

    // Both masters request continuously: grants alternate starting at master 0
    mw_addr = '0; mw_re = '1;
    acks = 0; expm = (m_last + 1) % MC;
    for (int cyc = 0; cyc < 60 && acks < 8; cyc++) begin
      @(negedge clk);
      if (master_ack != '0) begin
        check($sformatf("rr_grant%0d", acks), 32'(master_ack), 32'(1 << expm));
        expm = (expm + 1) % MC; acks++;
      end
    end
    mw_re = '0;
    check("rr_count", 32'(acks), 8);
    m_last = (expm + MC - 1) % MC;
    @(negedge clk);

`ifdef CORE_MANAGEMENT_HUB_AUTO_HALT_EN
    model_access(0, 1, 20'h00000, 32'h1, 4'h1, 0, 32'h0, erd, eerr, elat);
    xact("ah_run", 0, 1, 20'h00000, 32'h1, 4'h1, 0, 32'h0, erd, eerr, elat);
    core_errorCode[3:0] = 4'h2;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("ah_halted", 32'(core_run[0]), 0);
    m_run = m_run & ~1;
    model_access(1, 0, 20'h00100, 32'h0, 4'hF, 0, 32'h0, erd, eerr, elat);
    xact("ah_state", 1, 0, 20'h00100, 32'h0, 4'hF, 0, 32'h0, 32'h2, 0, 2);
    core_errorCode = '0;
`endif

    check("mon_multi_ack", 32'(multi_ack), 0);
    check("mon_strobe_running", 32'(bad_strobe), 0);
    check("mon_stray_rdata", 32'(stray_rdata), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
